// File: rtl/grid_game_pkg.sv
// ----------------------------------------------------------------------------
// grid_game_pkg
//   Shared definitions for the grid memory game round engine:
//   - state_t   : sequencer state encodings (also shown on the HEX display)
//   - SND_*     : sound_select codes for the audio back end
//   - cell_idx_w: width of a cell index for a given board size
//   - cnt_w     : width of a counter that must hold 0..max_val
//   - max_of    : integer maximum, used to size the shared phase timer
// ----------------------------------------------------------------------------
package grid_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHOW  = 3'd2,
        ST_INPUT = 3'd3,
        ST_EVAL  = 3'd4,
        ST_DRAW  = 3'd5
    } state_t;

    localparam logic [1:0] SND_SHOW  = 2'd0;
    localparam logic [1:0] SND_FAIL  = 2'd1;
    localparam logic [1:0] SND_INPUT = 2'd2;
    localparam logic [1:0] SND_PASS  = 2'd3;

    function automatic int cell_idx_w(input int cells);
        return (cells < 2) ? 1 : $clog2(cells);
    endfunction

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/grid_round_engine_if.sv
// ----------------------------------------------------------------------------
// grid_round_engine_if
//   Bundles every non-clock signal of the round engine.
//   Strobe semantics: start, cell_valid and submit are single-cycle strobes
//   sampled on the rising clock edge. There is no ready/back-pressure; a
//   strobe arriving in a state that does not accept it is simply dropped.
//   pat_data must be valid by the clock edge ending the cycle in which
//   pat_addr is presented.
//   Modports:
//     slave  - the round engine (consumes strobes/ROM data, drives outputs)
//     master - the surrounding game logic (keypad, LFSR, ROM, back ends)
// ----------------------------------------------------------------------------
interface grid_round_engine_if #(
    parameter int CELLS   = 9,
    parameter int LEVEL_W = 2,
    parameter int SEL_W   = 3
);
    import grid_game_pkg::*;

    localparam int IDX_W = cell_idx_w(CELLS);

    logic                     start;
    logic [SEL_W-1:0]         rnd_sel;
    logic [LEVEL_W+SEL_W-1:0] pat_addr;
    logic [CELLS-1:0]         pat_data;
    logic                     cell_valid;
    logic [IDX_W-1:0]         cell_idx;
    logic                     submit;
    logic [CELLS-1:0]         board_out;
    logic                     audio_en;
    logic [1:0]               sound_select;
    logic [2:0]               state_code;
    logic [LEVEL_W-1:0]       level;
    logic                     match;
    logic                     round_done;

    modport slave (
        input  start, rnd_sel, pat_data, cell_valid, cell_idx, submit,
        output pat_addr, board_out, audio_en, sound_select, state_code,
               level, match, round_done
    );

    modport master (
        output start, rnd_sel, pat_data, cell_valid, cell_idx, submit,
        input  pat_addr, board_out, audio_en, sound_select, state_code,
               level, match, round_done
    );

endinterface

// File: rtl/grid_round_engine_phase_timer.sv
// ----------------------------------------------------------------------------
// grid_round_engine_phase_timer
//   Loadable down-counter shared by the SHOW, DRAW and (optional) INPUT
//   timeout phases. Loading N-1 on phase entry makes tc rise in the N-th
//   cycle of the phase.
//   Ports:
//     clock, reset : clock, async active-high reset
//     clear        : force count to 0
//     load         : load load_val (priority below clear)
//     load_val     : value to load
//     en           : decrement while non-zero
//     tc           : terminal count, high while count is 0
// ----------------------------------------------------------------------------
module grid_round_engine_phase_timer #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/grid_round_engine.sv
// ----------------------------------------------------------------------------
// grid_round_engine
//   Datapath + sequencer for one round of the grid memory game: fetch a level
//   pattern from the external ROM, show it, collect presses, compare, then
//   advance or clear the level.
//   Ports:
//     clock, reset : system clock, async active-high reset
//     bus (slave)  : start/rnd_sel, pattern ROM address/data, keypad presses,
//                    submit, board/audio outputs, state_code (debug state),
//                    level, match, round_done
//   Configuration macro:
//     GRID_TIMEOUT_EN - when defined, an INPUT phase with no submit for
//                       TIMEOUT_CYC cycles proceeds to EVAL as if submitted.
// ----------------------------------------------------------------------------
module grid_round_engine
    import grid_game_pkg::*;
#(
    parameter int CELLS       = 9,
    parameter int LEVEL_W     = 2,
    parameter int SEL_W       = 3,
    parameter int SHOW_CYCLES = 1000,
    parameter int DRAW_CYCLES = 1000,
    parameter int TIMEOUT_CYC = 50000
) (
    input logic               clock,
    input logic               reset,
    grid_round_engine_if.slave bus
);

`ifdef GRID_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // One timer serves every timed phase, so it is sized for the longest.
    localparam int TIMER_MAX = max_of(max_of(SHOW_CYCLES, DRAW_CYCLES),
                                      TO_EN ? TIMEOUT_CYC : 1);
    localparam int CNT_W = cnt_w(TIMER_MAX);

    localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAW_LD  = CNT_W'(DRAW_CYCLES - 1);
`ifdef GRID_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TIMEOUT_CYC - 1);
`endif
    localparam logic [CELLS-1:0] CELL_ONE = CELLS'(1);

    state_t               state;
    logic [SEL_W-1:0]     sel_q;
    logic [CELLS-1:0]     pattern;
    logic [CELLS-1:0]     user_pat;
    logic [CELLS-1:0]     board_q;
    logic                 audio_q;
    logic [1:0]           snd_q;
    logic [LEVEL_W-1:0]   level_q;
    logic                 match_q;
    logic                 done_q;

    logic                 press_ok;
    logic [CELLS-1:0]     press_mask;
    logic [CELLS-1:0]     user_nxt;
    logic                 input_done;

    logic                 tmr_clear;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_en;
    logic                 tmr_tc;

    assign bus.pat_addr     = {level_q, sel_q};
    assign bus.board_out    = board_q;
    assign bus.audio_en     = audio_q;
    assign bus.sound_select = snd_q;
    assign bus.state_code   = state;
    assign bus.level        = level_q;
    assign bus.match        = match_q;
    assign bus.round_done   = done_q;

    // Out-of-range indices (possible when CELLS is not a power of two)
    // produce an all-zero mask, so they neither set a bit nor sound a tone.
    always_comb begin
        press_ok   = bus.cell_valid && (32'(bus.cell_idx) < 32'(CELLS));
        press_mask = press_ok ? (CELL_ONE << bus.cell_idx) : '0;
        user_nxt   = user_pat | press_mask;
    end

`ifdef GRID_TIMEOUT_EN
    assign input_done = bus.submit || tmr_tc;
`else
    assign input_done = bus.submit;
`endif

    // Timer control mirrors the FSM transitions: it is (re)loaded on the
    // edge that enters a timed phase and cleared when leaving one.
    always_comb begin
        tmr_clear = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;
        case (state)
            ST_LOAD: begin
                tmr_load = 1'b1;
                tmr_val  = SHOW_LD;
            end
            ST_SHOW: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
`ifdef GRID_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TO_LD;
`else
                    tmr_clear = 1'b1;
`endif
                end
            end
            ST_INPUT: begin
`ifdef GRID_TIMEOUT_EN
                tmr_en = 1'b1;
`endif
                if (input_done) tmr_clear = 1'b1;
            end
            ST_EVAL: begin
                tmr_load = 1'b1;
                tmr_val  = DRAW_LD;
            end
            ST_DRAW: begin
                tmr_en = 1'b1;
                if (tmr_tc) tmr_clear = 1'b1;
            end
            default: tmr_clear = 1'b1;
        endcase
    end

    grid_round_engine_phase_timer #(.W(CNT_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            sel_q    <= '0;
            pattern  <= '0;
            user_pat <= '0;
            board_q  <= '0;
            audio_q  <= 1'b0;
            snd_q    <= SND_SHOW;
            level_q  <= '0;
            match_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            audio_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    board_q <= '0;
                    if (bus.start) begin
                        sel_q <= bus.rnd_sel;
                        state <= ST_LOAD;
                    end
                end
                // pat_addr settled at the start of this cycle, so pat_data
                // is valid at the edge that ends it.
                ST_LOAD: begin
                    pattern  <= bus.pat_data;
                    user_pat <= '0;
                    board_q  <= bus.pat_data;
                    snd_q    <= SND_SHOW;
                    state    <= ST_SHOW;
                end
                ST_SHOW: begin
                    audio_q <= |(pattern & press_mask);
                    if (tmr_tc) begin
                        board_q <= user_pat;
                        snd_q   <= SND_INPUT;
                        state   <= ST_INPUT;
                    end
                end
                // A press in the submit cycle is merged before evaluation.
                ST_INPUT: begin
                    user_pat <= user_nxt;
                    board_q  <= user_nxt;
                    audio_q  <= press_ok;
                    if (input_done) state <= ST_EVAL;
                end
                ST_EVAL: begin
                    match_q <= (user_pat == pattern);
                    snd_q   <= (user_pat == pattern) ? SND_PASS : SND_FAIL;
                    audio_q <= 1'b1;
                    state   <= ST_DRAW;
                end
                ST_DRAW: begin
                    audio_q <= 1'b1;
                    if (tmr_tc) begin
                        level_q <= match_q ? level_q + 1'b1 : '0;
                        done_q  <= 1'b1;
                        audio_q <= 1'b0;
                        board_q <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
